// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the retire-trace link.
// Holds the record type, the transmit FSM state encoding, the header
// bit positions and a header-packing helper. The receiving checker uses
// the same header layout.
// Related block option: TRACE_COMPRESS_EN (used in retire_trace_tx.sv).
package trace_pkg;

  localparam logic [3:0] TRACE_SYNC = 4'hA;

  // Header word layout
  localparam int HDR_SYNC_LSB = 12;
  localparam int HDR_HLT_BIT  = 11;
  localparam int HDR_RW_BIT   = 10;
  localparam int HDR_MW_BIT   = 9;
  localparam int HDR_OVF_BIT  = 8;
  localparam int HDR_DST_LSB  = 4;
  localparam int HDR_SEQ_LSB  = 0;

  typedef struct packed {
    logic        hlt;
    logic        reg_write;
    logic        mem_write;
    logic        ovf;
    logic [3:0]  dst;
    logic [3:0]  seq;
    logic [15:0] pc;
    logic [15:0] data;
  } trace_rec_t;

  typedef enum logic [2:0] {IDLE, HDR, PC, DATA, DONE} trace_state_t;

  function automatic logic [15:0] make_hdr(input trace_rec_t rec);
    logic [15:0] h;
    h = '0;
    h[HDR_SYNC_LSB +: 4] = TRACE_SYNC;
    h[HDR_HLT_BIT]       = rec.hlt;
    h[HDR_RW_BIT]        = rec.reg_write;
    h[HDR_MW_BIT]        = rec.mem_write;
    h[HDR_OVF_BIT]       = rec.ovf;
    h[HDR_DST_LSB +: 4]  = rec.dst;
    h[HDR_SEQ_LSB +: 4]  = rec.seq;
    return h;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: DEPTH-entry synchronous FIFO of trace_rec_t.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_push, i_rec     write request and record
//   i_pop             read request (head advances)
//   o_head            current head record (valid when !o_empty)
//   o_full, o_empty   status
//   o_count           number of stored records
// A push while full is accepted when a pop happens on the same edge.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  trace_rec_t    i_rec,
  input  logic          i_pop,
  output trace_rec_t    o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  trace_rec_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_rec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/retire_trace_tx.sv
// retire_trace_tx: transmit end of the retire-trace interface.
// Captures one record per retiring instruction into a small FIFO and sends
// each as HDR, PC, DATA 16-bit words over a valid/ready handshake.
// Records that find the FIFO full are dropped and counted; the next
// accepted record carries the overflow flag in its header.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_ret_*                    retire record from WB
//   o_tx_valid/i_tx_ready      word handshake
//   o_tx_data, o_tx_last       trace word, last word of record
//   o_drop_cnt                 saturating count of dropped records
//   o_tx_done                  HLT record fully sent (sticky)
// Build option: TRACE_COMPRESS_EN sends records with no register write,
// no store and no halt as HDR+PC only.
module retire_trace_tx
  import trace_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ret_valid,
  input  logic [15:0]       i_ret_pc,
  input  logic              i_ret_hlt,
  input  logic              i_ret_reg_write,
  input  logic              i_ret_mem_write,
  input  logic [3:0]        i_ret_dst,
  input  logic [15:0]       i_ret_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [15:0]       o_tx_data,
  output logic              o_tx_last,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic              o_tx_done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  trace_state_t      r_state, w_state_nxt;
  logic              r_tx_valid, w_valid_nxt;
  logic [15:0]       r_tx_data, w_data_nxt;
  logic              r_tx_last, w_last_nxt;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              r_done;
  logic [3:0]        r_seq;
  logic              r_ovf;
  logic [15:0]       r_cur_pc;
  logic [15:0]       r_cur_data;
  logic              r_cur_hlt;
  logic              r_cur_short;

  trace_rec_t        w_new_rec;
  trace_rec_t        w_head;
  logic              w_full, w_empty;
  logic [CW-1:0]     w_count;
  logic              w_push, w_drop, w_pop, w_hs, w_rec_end, w_head_short;

  assign w_new_rec = '{hlt: i_ret_hlt, reg_write: i_ret_reg_write,
                       mem_write: i_ret_mem_write, ovf: r_ovf, dst: i_ret_dst,
                       seq: r_seq, pc: i_ret_pc, data: i_ret_data};

  // A full FIFO still accepts when the FSM pops on the same edge.
  assign w_push = i_ret_valid && (r_state != DONE) && ((w_count < CW'(DEPTH)) || w_pop);
  assign w_drop = i_ret_valid && (r_state != DONE) && w_full && !w_pop;
  assign w_hs   = r_tx_valid && i_tx_ready;

`ifdef TRACE_COMPRESS_EN
  assign w_head_short = !w_head.hlt && !w_head.reg_write && !w_head.mem_write;
`else
  assign w_head_short = 1'b0;
`endif

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_rec   (w_new_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_tx_last   <= 1'b0;
      r_drop_cnt  <= '0;
      r_done      <= 1'b0;
      r_seq       <= '0;
      r_ovf       <= 1'b0;
      r_cur_pc    <= '0;
      r_cur_data  <= '0;
      r_cur_hlt   <= 1'b0;
      r_cur_short <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_valid <= w_valid_nxt;
      r_tx_data  <= w_data_nxt;
      r_tx_last  <= w_last_nxt;
      r_done     <= (w_state_nxt == DONE);
      if (w_pop) begin
        r_cur_pc    <= w_head.pc;
        r_cur_data  <= w_head.data;
        r_cur_hlt   <= w_head.hlt;
        r_cur_short <= w_head_short;
      end
      if (w_push) begin
        r_seq <= r_seq + 1'b1;
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != DROP_MAX) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_tx_valid;
    w_data_nxt  = r_tx_data;
    w_last_nxt  = r_tx_last;
    w_pop       = 1'b0;
    w_rec_end   = 1'b0;
    case (r_state)
      IDLE: w_rec_end = 1'b1;
      HDR: begin
        if (w_hs) begin
          w_state_nxt = PC;
          w_data_nxt  = r_cur_pc;
          w_last_nxt  = r_cur_short;
        end
      end
      PC: begin
        if (w_hs) begin
          if (r_cur_short) begin
            w_rec_end = 1'b1;
          end else begin
            w_state_nxt = DATA;
            w_data_nxt  = r_cur_data;
            w_last_nxt  = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_hs) begin
          if (r_cur_hlt) begin
            w_state_nxt = DONE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
          end else begin
            w_rec_end = 1'b1;
          end
        end
      end
      DONE: begin
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Record finished (or idle): start the next one without a bubble.
    if (w_rec_end) begin
      if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = HDR;
        w_valid_nxt = 1'b1;
        w_data_nxt  = make_hdr(w_head);
        w_last_nxt  = 1'b0;
      end else begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    end
  end

  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tx_data;
  assign o_tx_last  = r_tx_last;
  assign o_drop_cnt = r_drop_cnt;
  assign o_tx_done  = r_done;

endmodule
